// File: rtl/uart_receiver_if.sv
// uart_receiver_if: host-side bus of the UART receiver.
//   read_enable      host -> rx  pop head of receive buffer
//   buffer_threshold host -> rx  level at which buffer_ready asserts
//   data_out         rx -> host  head of receive buffer (first-word fall-through)
//   buffer_empty     rx -> host  buffer holds no bytes
//   buffer_ready     rx -> host  count >= buffer_threshold and count != 0
//   frame_error      rx -> host  1-cycle pulse, stop bit sampled low
//   overrun_error    rx -> host  1-cycle pulse, good byte dropped on full buffer
`timescale 1ns/1ps
interface uart_receiver_if;
    logic       read_enable;
    logic [5:0] buffer_threshold;
    logic [7:0] data_out;
    logic       buffer_empty;
    logic       buffer_ready;
    logic       frame_error;
    logic       overrun_error;

    modport master (
        output read_enable,
        output buffer_threshold,
        input  data_out,
        input  buffer_empty,
        input  buffer_ready,
        input  frame_error,
        input  overrun_error
    );

    modport slave (
        input  read_enable,
        input  buffer_threshold,
        output data_out,
        output buffer_empty,
        output buffer_ready,
        output frame_error,
        output overrun_error
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver (LSB first, idle high) feeding a 64-entry
// first-word-fall-through receive buffer drained by the host.
// Ports:
//   clock           system clock, all logic on posedge
//   reset           synchronous active-high reset
//   data_in         serial line, idle high
//   baudrate_select selects BIT_CYCLES_n, latched at start detection
//   host            uart_receiver_if.slave (read strobe, threshold, data and status)
`timescale 1ns/1ps
module uart_receiver #(
    parameter int unsigned BIT_CYCLES_0 = 5208,
    parameter int unsigned BIT_CYCLES_1 = 2604,
    parameter int unsigned BIT_CYCLES_2 = 868,
    parameter int unsigned BIT_CYCLES_3 = 434,
    parameter int unsigned BUFFER_DEPTH = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            data_in,
    input  logic [1:0]      baudrate_select,
    uart_receiver_if.slave  host
);

    localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // ------------------------------------------------------------------
    // Input synchroniser; flops reset high so reset looks like an idle line.
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic line;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] bit_cycles_q;
    logic [15:0] sel_cycles;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        start_done;
    logic        bit_done;

    // Strobes from the output process
    logic load_baud;
    logic cnt_clear;
    logic shift_en;
    logic stop_eval;

    always_comb begin
        unique case (baudrate_select)
            2'd0: sel_cycles = 16'(BIT_CYCLES_0);
            2'd1: sel_cycles = 16'(BIT_CYCLES_1);
            2'd2: sel_cycles = 16'(BIT_CYCLES_2);
            2'd3: sel_cycles = 16'(BIT_CYCLES_3);
        endcase
    end

    // Half-bit wait in START lands the data samples mid-bit.
    assign start_done = (cnt_q == (bit_cycles_q >> 1) - 16'd1);
    assign bit_done   = (cnt_q == bit_cycles_q - 16'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!line) state_d = StStart;
            end
            StStart: begin
                // A line back high at mid-start is a glitch: drop silently.
                if (start_done) state_d = line ? StIdle : StData;
            end
            StData: begin
                if (bit_done && bit_idx_q == 3'd7) state_d = StStop;
            end
            StStop: begin
                // No wait for the end of the stop bit so frames can abut.
                if (bit_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_baud = 1'b0;
        cnt_clear = 1'b0;
        shift_en  = 1'b0;
        stop_eval = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_clear = 1'b1;
                load_baud = !line;
            end
            StStart: begin
                cnt_clear = start_done;
            end
            StData: begin
                cnt_clear = bit_done;
                shift_en  = bit_done;
            end
            StStop: begin
                cnt_clear = bit_done;
                stop_eval = bit_done;
            end
            default: cnt_clear = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer bookkeeping (next-state)
    // ------------------------------------------------------------------
    logic [7:0]      mem_q [BUFFER_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            push_pending_q;
    logic            push, pop;
    logic            full_next;
    logic            frame_error_q, overrun_error_q, buffer_ready_q;

    assign pop  = host.read_enable && (count_q != '0);
    // A slot freed by a same-edge pop makes room even when full.
    assign push = push_pending_q && ((count_q != CntW'(BUFFER_DEPTH)) || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
    end

    // The byte is pushed one edge after the stop sample; judging space on the
    // post-update count reserves the slot for that push.
    assign full_next = (count_d == CntW'(BUFFER_DEPTH));

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q           <= '0;
            bit_cycles_q    <= 16'(BIT_CYCLES_0);
            bit_idx_q       <= '0;
            shift_q         <= '0;
            push_pending_q  <= 1'b0;
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            if (load_baud) bit_cycles_q <= sel_cycles;
            cnt_q <= cnt_clear ? 16'd0 : cnt_q + 16'd1;
            if (state_q == StIdle) bit_idx_q <= '0;
            if (shift_en) begin
                bit_idx_q <= bit_idx_q + 3'd1;
                shift_q   <= {line, shift_q[7:1]};
            end
            frame_error_q   <= stop_eval && !line;
            overrun_error_q <= stop_eval && line && full_next;
            push_pending_q  <= stop_eval && line && !full_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            buffer_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q        <= count_d;
            buffer_ready_q <= (count_d >= {1'b0, host.buffer_threshold}) && (count_d != '0);
        end
    end

    // Storage has no reset; the empty flag masks stale contents.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    // ------------------------------------------------------------------
    // Host outputs
    // ------------------------------------------------------------------
    assign host.buffer_empty  = (count_q == '0);
    assign host.data_out      = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign host.buffer_ready  = buffer_ready_q;
    assign host.frame_error   = frame_error_q;
    assign host.overrun_error = overrun_error_q;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int unsigned B0 = 16;
    localparam int unsigned B3 = 8;
    // Edges from the first low drive to buffer_empty falling: 3 to reach
    // START, B/2 in START, 9*B to the stop sample, 1 more for the push.
    localparam int FALL0 = 4 + B0 / 2 + 9 * B0;
    localparam int FALL3 = 4 + B3 / 2 + 9 * B3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b1;
    logic [1:0] baudrate_select = 2'd0;

    int n_vec  = 0;
    int n_miss = 0;

    uart_receiver_if bus ();

    uart_receiver #(
        .BIT_CYCLES_0 (B0),
        .BIT_CYCLES_3 (B3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .data_in         (data_in),
        .baudrate_select (baudrate_select),
        .host            (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
        data_in = 1'b0;
        step(bc);
        for (int i = 0; i < 8; i++) begin
            data_in = b[i];
            step(bc);
        end
        data_in = stop;
        step(bc);
        data_in = 1'b1;
    endtask

    // Records event edges counted from the call (edge 1 = first posedge).
    task automatic watch(input int n, output int fall_at, output int fe_cnt,
                         output int fe_at, output int ov_cnt, output int ov_at);
        fall_at = 0; fe_cnt = 0; fe_at = 0; ov_cnt = 0; ov_at = 0;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (fall_at == 0 && !bus.buffer_empty) fall_at = i;
            if (bus.frame_error) begin
                fe_cnt++;
                if (fe_at == 0) fe_at = i;
            end
            if (bus.overrun_error) begin
                ov_cnt++;
                if (ov_at == 0) ov_at = i;
            end
        end
    endtask

    task automatic pop_one();
        bus.read_enable = 1'b1;
        step(1);
        bus.read_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        n_vec++; if (bus.data_out !== 8'h00) begin n_miss++; $display("FAIL reset_data got %h want 00", bus.data_out); end
        n_vec++; if (bus.buffer_empty !== 1'b1) begin n_miss++; $display("FAIL reset_empty got %b want 1", bus.buffer_empty); end
        n_vec++; if (bus.buffer_ready !== 1'b0) begin n_miss++; $display("FAIL reset_ready got %b want 0", bus.buffer_ready); end
        n_vec++; if (bus.frame_error !== 1'b0) begin n_miss++; $display("FAIL reset_fe got %b want 0", bus.frame_error); end
        n_vec++; if (bus.overrun_error !== 1'b0) begin n_miss++; $display("FAIL reset_ov got %b want 0", bus.overrun_error); end
    endtask

    task automatic test_basic();
        int fall_at, fe_cnt, fe_at, ov_cnt, ov_at;
        fork
            send_frame(8'hA5, 1'b1, B0);
            watch(11 * B0 + 4, fall_at, fe_cnt, fe_at, ov_cnt, ov_at);
        join
        n_vec++; if (fall_at !== FALL0) begin n_miss++; $display("FAIL basic_latency got %0d want %0d", fall_at, FALL0); end
        n_vec++; if (bus.data_out !== 8'hA5) begin n_miss++; $display("FAIL basic_data got %h want a5", bus.data_out); end
        n_vec++; if (fe_cnt + ov_cnt !== 0) begin n_miss++; $display("FAIL basic_errors got %0d want 0", fe_cnt + ov_cnt); end
        pop_one();
        n_vec++; if (bus.buffer_empty !== 1'b1) begin n_miss++; $display("FAIL basic_pop_empty got %b want 1", bus.buffer_empty); end
        n_vec++; if (bus.data_out !== 8'h00) begin n_miss++; $display("FAIL basic_pop_data got %h want 00", bus.data_out); end
    endtask

    task automatic test_frame_error();
        int fall_at, fe_cnt, fe_at, ov_cnt, ov_at;
        fork
            send_frame(8'h3C, 1'b0, B0);
            watch(11 * B0 + 4, fall_at, fe_cnt, fe_at, ov_cnt, ov_at);
        join
        n_vec++; if (fe_cnt !== 1) begin n_miss++; $display("FAIL fe_width got %0d want 1", fe_cnt); end
        n_vec++; if (fe_at !== FALL0 - 1) begin n_miss++; $display("FAIL fe_time got %0d want %0d", fe_at, FALL0 - 1); end
        n_vec++; if (fall_at !== 0) begin n_miss++; $display("FAIL fe_no_push got %0d want 0", fall_at); end
        step(2 * B0);
        fork
            send_frame(8'h55, 1'b1, B0);
            watch(11 * B0 + 4, fall_at, fe_cnt, fe_at, ov_cnt, ov_at);
        join
        n_vec++; if (bus.data_out !== 8'h55) begin n_miss++; $display("FAIL fe_next_data got %h want 55", bus.data_out); end
        n_vec++; if (fe_cnt !== 0) begin n_miss++; $display("FAIL fe_next_err got %0d want 0", fe_cnt); end
        pop_one();
    endtask

    task automatic test_glitch();
        int fall_at, fe_cnt, fe_at, ov_cnt, ov_at;
        fork
            begin
                data_in = 1'b0;
                step(4);
                data_in = 1'b1;
            end
            watch(3 * B0, fall_at, fe_cnt, fe_at, ov_cnt, ov_at);
        join
        n_vec++; if (fall_at + fe_cnt + ov_cnt !== 0) begin n_miss++; $display("FAIL glitch_quiet got %0d want 0", fall_at + fe_cnt + ov_cnt); end
        fork
            send_frame(8'h81, 1'b1, B0);
            watch(11 * B0 + 4, fall_at, fe_cnt, fe_at, ov_cnt, ov_at);
        join
        n_vec++; if (fall_at !== FALL0) begin n_miss++; $display("FAIL glitch_latency got %0d want %0d", fall_at, FALL0); end
        n_vec++; if (bus.data_out !== 8'h81) begin n_miss++; $display("FAIL glitch_data got %h want 81", bus.data_out); end
        pop_one();
    endtask

    task automatic test_back_to_back_overrun();
        int fall_at, fe_cnt, fe_at, ov_cnt, ov_at;
        logic [7:0] want;
        for (int i = 0; i < 64; i++) send_frame(8'(i), 1'b1, B0);
        step(4);
        n_vec++; if (bus.data_out !== 8'h00) begin n_miss++; $display("FAIL full_head got %h want 00", bus.data_out); end
        fork
            send_frame(8'hFF, 1'b1, B0);
            watch(11 * B0 + 4, fall_at, fe_cnt, fe_at, ov_cnt, ov_at);
        join
        n_vec++; if (ov_cnt !== 1) begin n_miss++; $display("FAIL ov_width got %0d want 1", ov_cnt); end
        n_vec++; if (ov_at !== FALL0 - 1) begin n_miss++; $display("FAIL ov_time got %0d want %0d", ov_at, FALL0 - 1); end
        n_vec++; if (fe_cnt !== 0) begin n_miss++; $display("FAIL ov_fe got %0d want 0", fe_cnt); end
        for (int i = 0; i < 64; i++) begin
            want = 8'(i);
            n_vec++;
            if (bus.buffer_empty !== 1'b0 || bus.data_out !== want) begin
                n_miss++;
                $display("FAIL drain_%0d got %h empty %b want %h empty 0", i, bus.data_out, bus.buffer_empty, want);
            end
            pop_one();
        end
        n_vec++; if (bus.buffer_empty !== 1'b1) begin n_miss++; $display("FAIL drain_end got %b want 1", bus.buffer_empty); end
    endtask

    task automatic test_threshold();
        bus.buffer_threshold = 6'd3;
        send_frame(8'h11, 1'b1, B0);
        send_frame(8'h22, 1'b1, B0);
        step(2);
        n_vec++; if (bus.buffer_ready !== 1'b0) begin n_miss++; $display("FAIL thr_two got %b want 0", bus.buffer_ready); end
        send_frame(8'h33, 1'b1, B0);
        step(2);
        n_vec++; if (bus.buffer_ready !== 1'b1) begin n_miss++; $display("FAIL thr_three got %b want 1", bus.buffer_ready); end
        pop_one();
        n_vec++; if (bus.buffer_ready !== 1'b0) begin n_miss++; $display("FAIL thr_pop got %b want 0", bus.buffer_ready); end
        n_vec++; if (bus.data_out !== 8'h22) begin n_miss++; $display("FAIL thr_data got %h want 22", bus.data_out); end
        pop_one();
        pop_one();
        bus.buffer_threshold = 6'd0;
    endtask

    task automatic test_reset_mid_frame();
        int fall_at, fe_cnt, fe_at, ov_cnt, ov_at;
        logic [7:0] b;
        b = 8'h5A;
        data_in = 1'b0;
        step(B0);
        for (int i = 0; i < 4; i++) begin
            data_in = b[i];
            step(B0);
        end
        data_in = b[4];
        step(5);
        reset = 1'b1;
        data_in = 1'b1;
        step(1);
        reset = 1'b0;
        n_vec++; if (bus.buffer_empty !== 1'b1 || bus.data_out !== 8'h00) begin n_miss++; $display("FAIL mid_reset_buf got %h/%b want 00/1", bus.data_out, bus.buffer_empty); end
        n_vec++; if (bus.buffer_ready !== 1'b0 || bus.frame_error !== 1'b0 || bus.overrun_error !== 1'b0) begin n_miss++; $display("FAIL mid_reset_flags got %b%b%b want 000", bus.buffer_ready, bus.frame_error, bus.overrun_error); end
        step(8 * B0);
        n_vec++; if (bus.buffer_empty !== 1'b1) begin n_miss++; $display("FAIL mid_no_push got %b want 1", bus.buffer_empty); end
        baudrate_select = 2'd3;
        fork
            send_frame(8'hC3, 1'b1, B3);
            watch(11 * B3 + 4, fall_at, fe_cnt, fe_at, ov_cnt, ov_at);
            begin
                // Mid-frame change must not disturb the latched rate.
                step(3 * B3);
                baudrate_select = 2'd0;
            end
        join
        n_vec++; if (fall_at !== FALL3) begin n_miss++; $display("FAIL fast_latency got %0d want %0d", fall_at, FALL3); end
        n_vec++; if (bus.data_out !== 8'hC3) begin n_miss++; $display("FAIL fast_data got %h want c3", bus.data_out); end
        n_vec++; if (bus.buffer_ready !== 1'b1) begin n_miss++; $display("FAIL fast_ready got %b want 1", bus.buffer_ready); end
    endtask

    initial begin
        bus.read_enable      = 1'b0;
        bus.buffer_threshold = 6'd0;
        step(1);
        test_reset();
        test_basic();
        test_frame_error();
        test_glitch();
        test_back_to_back_overrun();
        test_threshold();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
